// File: rtl/esp8266_frame_serializer.sv
// esp8266_frame_serializer
// Purpose : turns one latched 256-bit sensor frame into the ESP8266 SPI-slave
//           write transaction (CMD, ADDR, 32 payload bytes LSB byte first, and
//           optionally a CRC-8 byte). The bytes are handed to a byte-wide
//           spi_master through its wren/di_req/wr_ack handshake.
// Latency : frame_valid_i at edge N gives wren_o=1 with CMD_BYTE after edge N.
//           The next byte follows the edge that samples a di_req_i rise, or one
//           cycle after WAIT_REQ entry if that rise was already pending.
//           done_o follows the edge that samples the ss_n_i rise.
// Backpressure: one byte is in flight at a time. Start requests that arrive
//           while busy, or on the done/error cycle, are dropped and counted.
//
// Optional feature: define SERIALIZER_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0x00, MSB first, no final XOR) over the 32 payload bytes.
// The transaction is then 35 bytes instead of 34.
//
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   frame_i         256-bit frame, sampled only when frame_valid_i=1 in IDLE
//   frame_valid_i   single-cycle start request
//   di_req_i        spi_master requests the next byte (rising edge is the event)
//   write_ack_i     spi_master accepted data_byte_o
//   ss_n_i          spi_master slave select; a 0->1 edge ends the transfer
//   data_byte_o     byte presented to spi_master
//   wren_o          write enable to spi_master
//   busy_o          transaction in progress
//   done_o          one-cycle pulse, transaction complete
//   error_o         one-cycle pulse, transaction aborted on timeout
//   dropped_o       saturating count of ignored start requests
module esp8266_frame_serializer #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] CMD_BYTE       = 8'h02,
  parameter logic [7:0] ADDR_BYTE      = 8'h00
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [255:0] frame_i,
  input  logic         frame_valid_i,
  input  logic         di_req_i,
  input  logic         write_ack_i,
  input  logic         ss_n_i,
  output logic [7:0]   data_byte_o,
  output logic         wren_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         error_o,
  output logic [7:0]   dropped_o
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

`ifdef SERIALIZER_CRC_EN
  localparam logic [5:0] LAST_IDX = 6'd34;
`else
  localparam logic [5:0] LAST_IDX = 6'd33;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REQ = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  // Registered state
  state_t         r_state;
  logic [255:0]   r_frame;
  logic [5:0]     r_index;
  logic [7:0]     r_data_byte;
  logic           r_wren;
  logic           r_busy;
  logic           r_done;
  logic           r_error;
  logic [7:0]     r_dropped;
  logic           r_di_req_q;
  logic           r_ss_n_q;
  logic           r_req_pend;
  logic [TW-1:0]  r_timeout;

  // Next-state values
  state_t         w_state_nxt;
  logic [255:0]   w_frame_nxt;
  logic [5:0]     w_index_nxt;
  logic [7:0]     w_data_nxt;
  logic           w_wren_nxt;
  logic           w_busy_nxt;
  logic           w_done_nxt;
  logic           w_error_nxt;
  logic [7:0]     w_dropped_nxt;
  logic           w_pend_nxt;
  logic [TW-1:0]  w_timeout_nxt;
  logic           w_drop;

  // Datapath helpers
  logic           w_di_req_rise;
  logic           w_ss_rise;
  logic           w_expire;
  logic [4:0]     w_pay_sel;
  logic [7:0]     w_pay_byte;
  logic [7:0]     w_next_byte;

`ifdef SERIALIZER_CRC_EN
  logic [7:0]     r_crc;
  logic [7:0]     w_crc_nxt;

  // Byte-at-a-time form of the MSB-first CRC-8 shift register.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  assign w_di_req_rise = di_req_i & ~r_di_req_q;
  assign w_ss_rise     = ss_n_i & ~r_ss_n_q;

  // The counter aborts on the cycle it would reach zero, so a wait state
  // lasts exactly TIMEOUT_CYCLES cycles before error_o is raised.
  assign w_expire      = (r_timeout <= TW'(1));

  // Payload byte k sits at frame[8k+7:8k]; index 2 maps to payload byte 0.
  assign w_pay_sel     = 5'(r_index - 6'd2);
  assign w_pay_byte    = r_frame[{w_pay_sel, 3'b000} +: 8];

  always_comb begin
    w_next_byte = w_pay_byte;
    if (r_index == 6'd0) begin
      w_next_byte = CMD_BYTE;
    end else if (r_index == 6'd1) begin
      w_next_byte = ADDR_BYTE;
    end
`ifdef SERIALIZER_CRC_EN
    else if (r_index == 6'd34) begin
      w_next_byte = r_crc;
    end
`endif
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_index_nxt = r_index;
    w_data_nxt  = r_data_byte;
    w_wren_nxt  = r_wren;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    w_pend_nxt  = r_req_pend;
    w_drop      = 1'b0;
`ifdef SERIALIZER_CRC_EN
    w_crc_nxt   = r_crc;
`endif

    case (r_state)
      IDLE: begin
        w_pend_nxt = 1'b0;
        if (frame_valid_i) begin
          // The cycle right after completion or abort still counts as busy
          // for start requests, even though busy_o has already dropped.
          if (r_done || r_error) begin
            w_drop = 1'b1;
          end else begin
            w_frame_nxt = frame_i;
            w_index_nxt = 6'd0;
            w_data_nxt  = CMD_BYTE;
            w_wren_nxt  = 1'b1;
            w_state_nxt = WAIT_ACK;
`ifdef SERIALIZER_CRC_EN
            w_crc_nxt   = 8'h00;
`endif
          end
        end
      end

      WAIT_ACK: begin
        // A request edge seen here, including the ack cycle, is remembered so
        // WAIT_REQ does not miss it.
        if (w_di_req_rise) begin
          w_pend_nxt = 1'b1;
        end
        if (write_ack_i) begin
          w_wren_nxt = 1'b0;
          if (r_index == LAST_IDX) begin
            w_state_nxt = WAIT_END;
          end else begin
            w_index_nxt = r_index + 6'd1;
            w_state_nxt = WAIT_REQ;
          end
        end else if (w_expire) begin
          w_wren_nxt  = 1'b0;
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      WAIT_REQ: begin
        if (r_req_pend || w_di_req_rise) begin
          w_pend_nxt  = 1'b0;
          w_data_nxt  = w_next_byte;
          w_wren_nxt  = 1'b1;
          w_state_nxt = WAIT_ACK;
`ifdef SERIALIZER_CRC_EN
          if ((r_index >= 6'd2) && (r_index <= 6'd33)) begin
            w_crc_nxt = crc8_byte(r_crc, w_pay_byte);
          end
`endif
        end else if (w_expire) begin
          w_wren_nxt  = 1'b0;
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      WAIT_END: begin
        if (w_ss_rise) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_wren_nxt  = 1'b0;
          w_error_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_wren_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase

    if (frame_valid_i && (r_state != IDLE)) begin
      w_drop = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != IDLE);

    if (w_drop && (r_dropped != 8'hFF)) begin
      w_dropped_nxt = r_dropped + 8'd1;
    end else begin
      w_dropped_nxt = r_dropped;
    end

    // Reload on every state change; count down only while waiting.
    if (w_state_nxt != r_state) begin
      w_timeout_nxt = TW'(TIMEOUT_CYCLES);
    end else if (r_state != IDLE) begin
      w_timeout_nxt = r_timeout - TW'(1);
    end else begin
      w_timeout_nxt = r_timeout;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_frame     <= '0;
      r_index     <= 6'd0;
      r_data_byte <= 8'h00;
      r_wren      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_dropped   <= 8'h00;
      r_di_req_q  <= 1'b0;
      r_ss_n_q    <= 1'b1;
      r_req_pend  <= 1'b0;
      r_timeout   <= TW'(TIMEOUT_CYCLES);
`ifdef SERIALIZER_CRC_EN
      r_crc       <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_frame     <= w_frame_nxt;
      r_index     <= w_index_nxt;
      r_data_byte <= w_data_nxt;
      r_wren      <= w_wren_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_dropped   <= w_dropped_nxt;
      r_di_req_q  <= di_req_i;
      r_ss_n_q    <= ss_n_i;
      r_req_pend  <= w_pend_nxt;
      r_timeout   <= w_timeout_nxt;
`ifdef SERIALIZER_CRC_EN
      r_crc       <= w_crc_nxt;
`endif
    end
  end

  assign data_byte_o = r_data_byte;
  assign wren_o      = r_wren;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign error_o     = r_error;
  assign dropped_o   = r_dropped;

endmodule

// File: tb/tb_esp8266_frame_serializer.sv
// tb_esp8266_frame_serializer
// Purpose : drives esp8266_frame_serializer through a small spi_master model
//           and compares each issued byte with a queue built from the frame.
// Latency : inputs change on the falling edge, outputs are read either on the
//           falling edge or 1 ns after the rising edge.
// Backpressure: the spi_master model paces acks and byte requests.
`timescale 1ns/1ps
module tb_esp8266_frame_serializer;

  localparam int TMO = 100;
`ifdef SERIALIZER_CRC_EN
  localparam int NBYTES = 35;
`else
  localparam int NBYTES = 34;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] frame_i = '0;
  logic         frame_valid_i = 1'b0;
  logic         di_req_i = 1'b0;
  logic         write_ack_i = 1'b0;
  logic         ss_n_i = 1'b1;
  logic [7:0]   data_byte_o;
  logic         wren_o;
  logic         busy_o;
  logic         done_o;
  logic         error_o;
  logic [7:0]   dropped_o;

  esp8266_frame_serializer #(
    .TIMEOUT_CYCLES(TMO),
    .CMD_BYTE      (8'h02),
    .ADDR_BYTE     (8'h00)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_i      (frame_i),
    .frame_valid_i(frame_valid_i),
    .di_req_i     (di_req_i),
    .write_ack_i  (write_ack_i),
    .ss_n_i       (ss_n_i),
    .data_byte_o  (data_byte_o),
    .wren_o       (wren_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .dropped_o    (dropped_o)
  );

  always #5 clock = ~clock;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   exp_q[$];
  int           exp_dropped = 0;
  int           n_rises = 0;
  bit           in_txn = 1'b0;
  bit           wren_q = 1'b0;
  logic [7:0]   held_byte = 8'h00;
  logic [7:0]   pin_msg[$];
  logic [255:0] test_frame;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Bit-serial CRC-8, poly 0x07, init 0, message bits MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // Expected byte stream of one transaction.
  task automatic model_push(input logic [255:0] f);
    logic [7:0] pay[$];
    exp_q.delete();
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    for (int k = 0; k < 32; k++) pay.push_back(f[8*k +: 8]);
    foreach (pay[i]) exp_q.push_back(pay[i]);
`ifdef SERIALIZER_CRC_EN
    exp_q.push_back(model_crc(pay));
`endif
  endtask

  function automatic int sat_inc(input int v, input int n);
    return (v + n > 255) ? 255 : v + n;
  endfunction

  // Compare process: every byte the DUT issues is checked against the model.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        wren_q = 1'b0;
      end else begin
        if (wren_o && !wren_q) begin
          n_rises++;
          held_byte = data_byte_o;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", data_byte_o);
          end else begin
            check($sformatf("byte%0d", n_rises - 1), int'(data_byte_o), int'(exp_q.pop_front()));
          end
        end else if (wren_o) begin
          check("byte_hold", int'(data_byte_o), int'(held_byte));
        end
        if (wren_o) check("wren_implies_busy", int'(busy_o), 1);
        if (in_txn && !error_o) check("busy_during_txn", int'(busy_o), 1);
        wren_q = wren_o;
      end
    end
  end

  task automatic start_frame(input logic [255:0] f);
    model_push(f);
    n_rises = 0;
    frame_i = f;
    frame_valid_i = 1'b1;
    @(negedge clock);
    frame_valid_i = 1'b0;
    frame_i = rand256();
    check("start_wren", int'(wren_o), 1);
    check("start_byte", int'(data_byte_o), 8'h02);
    check("start_busy", int'(busy_o), 1);
    in_txn = 1'b1;
  endtask

  // spi_master model. same_mode: 0 never, 1 always, 2 randomly raises di_req
  // in the ack cycle. withhold >= 0 stops serving when that byte appears.
  task automatic serve_frame(input int ack_d, input int req_d, input int same_mode,
                             input int withhold, input bit drop_on_done);
    bit same;
    int n;
    for (int b = 0; b < NBYTES; b++) begin
      n = 0;
      while (!wren_o && n < 200) begin
        @(negedge clock);
        n++;
      end
      if (!wren_o) begin
        check("wren_wait", int'(wren_o), 1);
        return;
      end
      ss_n_i = 1'b0;
      if (b == withhold) return;
      same = (same_mode == 1) || ((same_mode == 2) && ($urandom_range(0, 1) == 1));
      if (b == NBYTES - 1) same = 1'b0;
      repeat (ack_d) @(negedge clock);
      write_ack_i = 1'b1;
      if (same) di_req_i = 1'b1;
      @(negedge clock);
      write_ack_i = 1'b0;
      check("ack_drops_wren", int'(wren_o), 0);
      if (b != NBYTES - 1) begin
        if (same) begin
          di_req_i = 1'b0;
          @(negedge clock);
          check("pending_req_issue", int'(wren_o), 1);
        end else begin
          repeat (req_d - 1) @(negedge clock);
          check("wait_req_idle", int'(wren_o), 0);
          di_req_i = 1'b1;
          @(negedge clock);
          di_req_i = 1'b0;
          check("req_issue", int'(wren_o), 1);
        end
      end
    end
    repeat (3) @(negedge clock);
    check("no_early_done", int'(done_o), 0);
    check("busy_before_end", int'(busy_o), 1);
    ss_n_i = 1'b1;
    in_txn = 1'b0;
    @(negedge clock);
    check("done_pulse", int'(done_o), 1);
    check("idle_after_done", int'(busy_o), 0);
    if (drop_on_done) begin
      frame_valid_i = 1'b1;
      frame_i = rand256();
      exp_dropped = sat_inc(exp_dropped, 1);
    end
    @(negedge clock);
    frame_valid_i = 1'b0;
    check("done_width", int'(done_o), 0);
    check("no_restart", int'(wren_o), 0);
    check("byte_count", n_rises, NBYTES);
    check("queue_drained", exp_q.size(), 0);
    check("dropped", int'(dropped_o), exp_dropped);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    for (int k = 0; k < 32; k++) test_frame[8*k +: 8] = 8'(k);

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_data", int'(data_byte_o), 0);
    check("rst_wren", int'(wren_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_error", int'(error_o), 0);
    check("rst_dropped", int'(dropped_o), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_wren", int'(wren_o), 0);

    // Pin the model with hand-known values
    pin_msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check", int'(model_crc(pin_msg)), 8'hF4);
    model_push(test_frame);
    check("model_len", exp_q.size(), NBYTES);
    check("model_b0", int'(exp_q[0]), 8'h02);
    check("model_b1", int'(exp_q[1]), 8'h00);
    check("model_b3", int'(exp_q[3]), 8'h01);
    check("model_b33", int'(exp_q[33]), 8'h1F);

    // Incrementing frame, ack after 3, request 8 later
    start_frame(test_frame);
    serve_frame(3, 8, 0, -1, 0);

    // Three start requests during a transfer, each with a different frame
    start_frame(rand256());
    fork
      serve_frame(3, 8, 0, -1, 0);
      begin
        repeat (20) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
          frame_valid_i = 1'b1;
          frame_i = rand256();
          @(negedge clock);
          frame_valid_i = 1'b0;
          repeat (4) @(negedge clock);
        end
        exp_dropped = sat_inc(exp_dropped, 3);
      end
    join
    check("dropped_three", int'(dropped_o), 3);

    // di_req rising in the ack cycle, plus a request on the done cycle
    start_frame(test_frame);
    serve_frame(3, 8, 1, -1, 1);

    // Held start request saturates the drop counter
    start_frame(rand256());
    fork
      serve_frame(3, 8, 0, -1, 1);
      begin
        repeat (5) @(negedge clock);
        frame_valid_i = 1'b1;
        for (int i = 0; i < 260; i++) begin
          frame_i = rand256();
          @(negedge clock);
          exp_dropped = sat_inc(exp_dropped, 1);
        end
        frame_valid_i = 1'b0;
      end
    join
    check("dropped_saturated", int'(dropped_o), 255);

    // Randomized frames and pacing
    for (int t = 0; t < 4; t++) begin
      start_frame(rand256());
      serve_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 10)), 2, -1, 0);
    end

    // Timeout: ack withheld for byte 5
    start_frame(rand256());
    serve_frame(3, 8, 0, 5, 0);
    cyc = 0;
    while (!error_o && cyc < 3 * TMO) begin
      @(negedge clock);
      cyc++;
    end
    check("timeout_cycles", cyc, TMO);
    check("err_wren", int'(wren_o), 0);
    check("err_busy", int'(busy_o), 0);
    in_txn = 1'b0;
    exp_q.delete();
    ss_n_i = 1'b1;
    @(negedge clock);
    check("error_width", int'(error_o), 0);
    start_frame(rand256());
    serve_frame(2, 5, 0, -1, 0);

    // Reset mid-payload
    start_frame(rand256());
    serve_frame(3, 4, 0, 10, 0);
    reset_n = 1'b0;
    #1;
    check("arst_data", int'(data_byte_o), 0);
    check("arst_wren", int'(wren_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_done", int'(done_o), 0);
    check("arst_error", int'(error_o), 0);
    check("arst_dropped", int'(dropped_o), 0);
    exp_dropped = 0;
    in_txn = 1'b0;
    exp_q.delete();
    write_ack_i = 1'b0;
    di_req_i = 1'b0;
    ss_n_i = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_frame(rand256());
    serve_frame(3, 6, 2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
